i2c_slave_regmap_ctrl: RTL and testbench

I2C_SLAVE_REGMAP_CTRL -- requirements
Module: i2c_slave_regmap_ctrl

---
 rtl/i2c_slave_regmap_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i2c_slave_regmap_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regmap_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_slave_regmap_ctrl
//
// Bridges the byte streams of an I2C slave core to a simple register file.
// The first byte written in a transaction loads the register pointer. Any
// further written bytes are stored to consecutive registers. A read request
// from the slave core fetches the register at the pointer and presents it on
// the read stream. The pointer advances after each register access and keeps
// its value between transactions. This lets a write of the pointer, followed
// by a repeated-start read, return data starting at that pointer.
//
// Optional feature macro: I2C_REGMAP_PTR_WRAP_EN
//   defined   : the pointer wraps from 2^ADDR_WIDTH-1 back to 0
//   undefined : the pointer saturates at 2^ADDR_WIDTH-1
//
// Parameters:
//   ADDR_WIDTH        register index width (1..8)
//
// Ports:
//   clk               sole clock, rising edge
//   rst_n             asynchronous active-low reset
//   s_axis_wr_tdata   written byte from the slave core
//   s_axis_wr_tvalid  written byte valid
//   s_axis_wr_tlast   last written byte of the transaction
//   s_axis_wr_tready  written byte accepted (IDLE/WDATA only)
//   m_axis_rd_tdata   read byte to the slave core
//   m_axis_rd_tvalid  read byte valid
//   m_axis_rd_tready  read request/accept from the slave core
//   bus_addressed     slave core addressed status
//   reg_wr_en         single-cycle register write strobe
//   reg_wr_addr       register write index
//   reg_wr_data       register write data
//   reg_rd_en         single-cycle register read strobe
//   reg_rd_addr       register read index
//   reg_rd_data       register read data, valid one cycle after reg_rd_en
//   ptr               current register pointer
// ---------------------------------------------------------------------------
module i2c_slave_regmap_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_axis_wr_tdata,
    input  logic                  s_axis_wr_tvalid,
    input  logic                  s_axis_wr_tlast,
    output logic                  s_axis_wr_tready,
    output logic [7:0]            m_axis_rd_tdata,
    output logic                  m_axis_rd_tvalid,
    input  logic                  m_axis_rd_tready,
    input  logic                  bus_addressed,
    output logic                  reg_wr_en,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [7:0]            reg_wr_data,
    output logic                  reg_rd_en,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic [7:0]            reg_rd_data,
    output logic [ADDR_WIDTH-1:0] ptr
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        RD_ISSUE,
        RD_CAPTURE,
        RD_PRESENT
    } state_t;

    state_t                state, state_nxt;
    logic                  ready_en;
    logic                  bus_addr_q;
    logic                  addr_drop;
    logic                  wr_acc;

    logic [ADDR_WIDTH-1:0] ptr_nxt;
    logic                  wr_en_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [7:0]            wr_data_nxt;
    logic                  rd_en_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr_nxt;
    logic [7:0]            rd_tdata_nxt;
    logic                  rd_tvalid_nxt;

    // Bits of the pointer byte above ADDR_WIDTH are ignored by design.
    logic                  unused_tdata_bits;
    assign unused_tdata_bits = ^s_axis_wr_tdata;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
`ifdef I2C_REGMAP_PTR_WRAP_EN
        return p + 1'b1;
`else
        return (p == '1) ? p : p + 1'b1;
`endif
    endfunction

    // ready_en holds tready low until the first clock after reset release.
    assign s_axis_wr_tready = ready_en && ((state == IDLE) || (state == WDATA));
    assign wr_acc           = s_axis_wr_tvalid && s_axis_wr_tready;
    // Falling edge of bus_addressed ends the transaction in any state.
    assign addr_drop        = bus_addr_q && !bus_addressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            ready_en         <= 1'b0;
            bus_addr_q       <= 1'b0;
            ptr              <= '0;
            reg_wr_en        <= 1'b0;
            reg_wr_addr      <= '0;
            reg_wr_data      <= '0;
            reg_rd_en        <= 1'b0;
            reg_rd_addr      <= '0;
            m_axis_rd_tdata  <= '0;
            m_axis_rd_tvalid <= 1'b0;
        end else begin
            state            <= state_nxt;
            ready_en         <= 1'b1;
            bus_addr_q       <= bus_addressed;
            ptr              <= ptr_nxt;
            reg_wr_en        <= wr_en_nxt;
            reg_wr_addr      <= wr_addr_nxt;
            reg_wr_data      <= wr_data_nxt;
            reg_rd_en        <= rd_en_nxt;
            reg_rd_addr      <= rd_addr_nxt;
            m_axis_rd_tdata  <= rd_tdata_nxt;
            m_axis_rd_tvalid <= rd_tvalid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = reg_wr_addr;
        wr_data_nxt   = reg_wr_data;
        rd_en_nxt     = 1'b0;
        rd_addr_nxt   = reg_rd_addr;
        rd_tdata_nxt  = m_axis_rd_tdata;
        rd_tvalid_nxt = m_axis_rd_tvalid;

        if (addr_drop) begin
            state_nxt     = IDLE;
            rd_tvalid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, WDATA: begin
                    if (wr_acc) begin
                        if (state == IDLE) begin
                            ptr_nxt = s_axis_wr_tdata[ADDR_WIDTH-1:0];
                        end else begin
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = ptr;
                            wr_data_nxt = s_axis_wr_tdata;
                            ptr_nxt     = ptr_inc(ptr);
                        end
                        state_nxt = s_axis_wr_tlast ? IDLE : WDATA;
                    end else if (m_axis_rd_tready) begin
                        // The read strobe is registered, so it is high for
                        // the whole RD_ISSUE cycle.
                        state_nxt   = RD_ISSUE;
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = ptr;
                    end
                end
                RD_ISSUE: begin
                    state_nxt = RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    rd_tdata_nxt  = reg_rd_data;
                    rd_tvalid_nxt = 1'b1;
                    state_nxt     = RD_PRESENT;
                end
                RD_PRESENT: begin
                    if (m_axis_rd_tready) begin
                        rd_tvalid_nxt = 1'b0;
                        ptr_nxt       = ptr_inc(ptr);
                        state_nxt     = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regmap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regmap_ctrl
//
// Directed bench for i2c_slave_regmap_ctrl with ADDR_WIDTH=4. A small
// register-file responder returns preset contents one cycle after
// reg_rd_en. When reg_rd_en is low it returns 0xEE.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge after the rising edge being observed.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regmap_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_axis_wr_tdata;
    logic       s_axis_wr_tvalid;
    logic       s_axis_wr_tlast;
    logic       s_axis_wr_tready;
    logic [7:0] m_axis_rd_tdata;
    logic       m_axis_rd_tvalid;
    logic       m_axis_rd_tready;
    logic       bus_addressed;
    logic       reg_wr_en;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [3:0] reg_rd_addr;
    logic [7:0] reg_rd_data = 8'hEE;
    logic [3:0] ptr;

    logic [7:0] regs [16];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    i2c_slave_regmap_ctrl #(.ADDR_WIDTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_wr_tdata  (s_axis_wr_tdata),
        .s_axis_wr_tvalid (s_axis_wr_tvalid),
        .s_axis_wr_tlast  (s_axis_wr_tlast),
        .s_axis_wr_tready (s_axis_wr_tready),
        .m_axis_rd_tdata  (m_axis_rd_tdata),
        .m_axis_rd_tvalid (m_axis_rd_tvalid),
        .m_axis_rd_tready (m_axis_rd_tready),
        .bus_addressed    (bus_addressed),
        .reg_wr_en        (reg_wr_en),
        .reg_wr_addr      (reg_wr_addr),
        .reg_wr_data      (reg_wr_data),
        .reg_rd_en        (reg_rd_en),
        .reg_rd_addr      (reg_rd_addr),
        .reg_rd_data      (reg_rd_data),
        .ptr              (ptr)
    );

    always @(posedge clk) begin
        reg_rd_data <= reg_rd_en ? regs[reg_rd_addr] : 8'hEE;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One written byte, accepted on the next rising edge.
    task automatic wr_byte(input logic [7:0] d, input logic last);
        s_axis_wr_tdata  = d;
        s_axis_wr_tvalid = 1'b1;
        s_axis_wr_tlast  = last;
        @(negedge clk);
        s_axis_wr_tvalid = 1'b0;
        s_axis_wr_tlast  = 1'b0;
    endtask

    // Full read with tready held until the handshake.
    task automatic rd_byte(input string tag, input logic [3:0] exp_addr, input logic [7:0] exp_data);
        m_axis_rd_tready = 1'b1;
        @(negedge clk);
        chk({tag, "_rd_en"},   32'(reg_rd_en), 32'h1);
        chk({tag, "_rd_addr"}, 32'(reg_rd_addr), 32'(exp_addr));
        chk({tag, "_no_wr"},   32'(reg_wr_en), 32'h0);
        @(negedge clk);
        chk({tag, "_rd_en_pulse"}, 32'(reg_rd_en), 32'h0);
        chk({tag, "_tvalid_early"}, 32'(m_axis_rd_tvalid), 32'h0);
        @(negedge clk);
        chk({tag, "_tvalid"}, 32'(m_axis_rd_tvalid), 32'h1);
        chk({tag, "_tdata"},  32'(m_axis_rd_tdata), 32'(exp_data));
        @(negedge clk);
        m_axis_rd_tready = 1'b0;
        chk({tag, "_tvalid_drop"}, 32'(m_axis_rd_tvalid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        regs[0]  = 8'h0A;  regs[1]  = 8'h01;  regs[2]  = 8'h11;  regs[3]  = 8'h22;
        regs[4]  = 8'h33;  regs[5]  = 8'h55;  regs[6]  = 8'h66;  regs[7]  = 8'h77;
        regs[8]  = 8'h88;  regs[9]  = 8'h99;  regs[10] = 8'hAA;  regs[11] = 8'hBB;
        regs[12] = 8'hCC;  regs[13] = 8'hDD;  regs[14] = 8'hE0;  regs[15] = 8'hF0;

        rst_n            = 1'b0;
        s_axis_wr_tdata  = 8'h00;
        s_axis_wr_tvalid = 1'b0;
        s_axis_wr_tlast  = 1'b0;
        m_axis_rd_tready = 1'b0;
        bus_addressed    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tready",  32'(s_axis_wr_tready), 32'h0);
        chk("rst_tvalid",  32'(m_axis_rd_tvalid), 32'h0);
        chk("rst_tdata",   32'(m_axis_rd_tdata), 32'h0);
        chk("rst_wr_en",   32'(reg_wr_en), 32'h0);
        chk("rst_rd_en",   32'(reg_rd_en), 32'h0);
        chk("rst_ptr",     32'(ptr), 32'h0);
        chk("rst_wr_addr", 32'(reg_wr_addr), 32'h0);
        chk("rst_wr_data", 32'(reg_wr_data), 32'h0);
        chk("rst_rd_addr", 32'(reg_rd_addr), 32'h0);
        rst_n         = 1'b1;
        bus_addressed = 1'b1;
        #1;
        chk("rel_tready_low", 32'(s_axis_wr_tready), 32'h0);
        @(negedge clk);
        chk("rel_tready_high", 32'(s_axis_wr_tready), 32'h1);

        // Pointer byte 0x03, then data 0xA5, 0x5A (last)
        wr_byte(8'h03, 1'b0);
        chk("w0_wr_en", 32'(reg_wr_en), 32'h0);
        chk("w0_ptr",   32'(ptr), 32'h3);
        wr_byte(8'hA5, 1'b0);
        chk("w1_wr_en",   32'(reg_wr_en), 32'h1);
        chk("w1_wr_addr", 32'(reg_wr_addr), 32'h3);
        chk("w1_wr_data", 32'(reg_wr_data), 32'hA5);
        chk("w1_ptr",     32'(ptr), 32'h4);
        wr_byte(8'h5A, 1'b1);
        chk("w2_wr_en",   32'(reg_wr_en), 32'h1);
        chk("w2_wr_addr", 32'(reg_wr_addr), 32'h4);
        chk("w2_wr_data", 32'(reg_wr_data), 32'h5A);
        chk("w2_ptr",     32'(ptr), 32'h5);
        @(negedge clk);
        chk("w_pulse_end", 32'(reg_wr_en), 32'h0);
        chk("w_idle_rdy",  32'(s_axis_wr_tready), 32'h1);

        // Pointer 0x02 then three reads
        wr_byte(8'h02, 1'b1);
        chk("p2_ptr",   32'(ptr), 32'h2);
        chk("p2_wr_en", 32'(reg_wr_en), 32'h0);
        rd_byte("r2", 4'h2, 8'h11);
        rd_byte("r3", 4'h3, 8'h22);
        rd_byte("r4", 4'h4, 8'h33);
        chk("r_ptr", 32'(ptr), 32'h5);

        // Upper pointer-byte bits are ignored: 0xF7 selects register 7
        s_axis_wr_tdata  = 8'hF7;
        s_axis_wr_tvalid = 1'b1;
        s_axis_wr_tlast  = 1'b1;
        m_axis_rd_tready = 1'b1;
        @(negedge clk);
        s_axis_wr_tvalid = 1'b0;
        s_axis_wr_tlast  = 1'b0;
        chk("pri_ptr",   32'(ptr), 32'h7);
        chk("pri_rd_en", 32'(reg_rd_en), 32'h0);
        @(negedge clk);
        chk("pri_rd_en2",   32'(reg_rd_en), 32'h1);
        chk("pri_rd_addr",  32'(reg_rd_addr), 32'h7);
        @(negedge clk);
        @(negedge clk);
        chk("pri_tvalid", 32'(m_axis_rd_tvalid), 32'h1);
        chk("pri_tdata",  32'(m_axis_rd_tdata), 32'h77);
        @(negedge clk);
        m_axis_rd_tready = 1'b0;
        chk("pri_ptr_after", 32'(ptr), 32'h8);

        // Pointer at 0xF, two reads: wrap or saturate
        wr_byte(8'h0F, 1'b1);
        chk("e_ptr", 32'(ptr), 32'hF);
        rd_byte("eF", 4'hF, 8'hF0);
`ifdef I2C_REGMAP_PTR_WRAP_EN
        rd_byte("e2", 4'h0, 8'h0A);
        chk("e_ptr_end", 32'(ptr), 32'h1);
`else
        rd_byte("e2", 4'hF, 8'hF0);
        chk("e_ptr_end", 32'(ptr), 32'hF);
`endif

        // bus_addressed falls while the read byte is presented
        wr_byte(8'h03, 1'b1);
        m_axis_rd_tready = 1'b1;
        @(negedge clk);
        m_axis_rd_tready = 1'b0;
        chk("ab_rd_addr", 32'(reg_rd_addr), 32'h3);
        @(negedge clk);
        @(negedge clk);
        chk("ab_tvalid", 32'(m_axis_rd_tvalid), 32'h1);
        chk("ab_tdata",  32'(m_axis_rd_tdata), 32'h22);
        @(negedge clk);
        chk("ab_hold", 32'(m_axis_rd_tvalid), 32'h1);
        bus_addressed = 1'b0;
        @(negedge clk);
        chk("ab_drop_tvalid", 32'(m_axis_rd_tvalid), 32'h0);
        chk("ab_drop_ptr",    32'(ptr), 32'h3);
        chk("ab_drop_rdy",    32'(s_axis_wr_tready), 32'h1);
        bus_addressed = 1'b1;
        @(negedge clk);
        rd_byte("ab_re", 4'h3, 8'h22);
        chk("ab_ptr_end", 32'(ptr), 32'h4);

        // Reset asserted during RD_CAPTURE
        m_axis_rd_tready = 1'b1;
        @(negedge clk);
        chk("rc_rd_en", 32'(reg_rd_en), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rc_tvalid",  32'(m_axis_rd_tvalid), 32'h0);
        chk("rc_tdata",   32'(m_axis_rd_tdata), 32'h0);
        chk("rc_ptr",     32'(ptr), 32'h0);
        chk("rc_rd_en0",  32'(reg_rd_en), 32'h0);
        chk("rc_rd_addr", 32'(reg_rd_addr), 32'h0);
        chk("rc_tready",  32'(s_axis_wr_tready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rc_hold_rd_en",  32'(reg_rd_en), 32'h0);
            chk("rc_hold_tvalid", 32'(m_axis_rd_tvalid), 32'h0);
        end
        m_axis_rd_tready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rc_rel_rdy", 32'(s_axis_wr_tready), 32'h1);
        chk("rc_rel_ptr", 32'(ptr), 32'h0);
        chk("rc_rel_rd",  32'(reg_rd_en), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
